hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipelined CPU.
- Drives the 2-bit select of the execute-stage operand forwarding muxes (A and B), the decode-stage branch-compare forward selects, and the fetch/decode stall and execute flush.
- Keeps its own shadow pipeline of destination-register and write-control bits for E/M/W.
- Owns a busy counter for the multi-cycle mul/div unit.

Parameters:
- REG_W, 5, register-index width.
- MD_LATENCY, 32, cycles a mul/div occupies HI/LO after issue; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- RsD  in  REG_W  decode-stage source register 1
- RtD  in  REG_W  decode-stage source register 2
- WriteRegD  in  REG_W  decode-stage destination register (already muxed rt/rd)
- RegWriteD  in  1  decode instruction writes the register file
- MemtoRegD  in  1  decode instruction is a load
- BranchD  in  1  decode instruction is a branch compared in D
- MdStartD  in  1  decode instruction starts mul/div
- MdUseD  in  1  decode instruction reads HI/LO (mfhi/mflo) or is another mul/div start
- ForwardAE  out  2  E operand A select: 0 = register file, 1 = ResultW, 2 = ALUOutM; 3 is never driven
- ForwardBE  out  2  same encoding for operand B
- ForwardAD  out  1  D branch operand A takes ALUOutM
- ForwardBD  out  1  D branch operand B takes ALUOutM
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- FlushE  out  1  bubble into ID/EX
- MdBusy  out  1  mul/div counter nonzero

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high; all state is sampled on the rising edge of `clk`.
- Reset clears to 0:
  - shadow registers RsE, RtE, WriteRegE/M/W, RegWriteE/M/W, MemtoRegE/M;
  - the mul/div counter.
  - Consequence: all outputs are 0 from the first cycle after reset.
- Reset mid-mul/div: the counter clears and MdBusy drops next cycle.
- Shadow pipeline, per clock:
  - If FlushE = 1: E fields load 0 (bubble).
  - Otherwise: E fields load the D inputs.
  - M loads E and W loads M unconditionally.
  - StallD holds the real IF/ID register, so the D inputs stay stable while stalled.
- Forwarding (combinational from shadow state):
  - ForwardAE = 2 if RsE≠0, RegWriteM and RsE==WriteRegM.
  - Else ForwardAE = 1 if RsE≠0, RegWriteW and RsE==WriteRegW.
  - Else ForwardAE = 0.
  - M has priority over W.
  - ForwardBE follows the same rules using RtE.
  - ForwardAD = RsD≠0 & RegWriteM & RsD==WriteRegM; ForwardBD uses RtD.
- Stall sources:
  - lwstall = MemtoRegE & WriteRegE≠0 & (WriteRegE==RsD | WriteRegE==RtD).
  - branchstall = BranchD & [ (RegWriteE & WriteRegE≠0 & WriteRegE∈{RsD,RtD}) | (MemtoRegM & WriteRegM≠0 & WriteRegM∈{RsD,RtD}) ].
  - mdstall = MdUseD & MdBusy.
  - stall = lwstall | branchstall | mdstall.
  - StallF = StallD = FlushE = stall, all combinational.
  - Register $0 never causes a forward or a stall.
- Mul/div counter, width clog2(MD_LATENCY+1):
  - Accept: MdStartD & ~stall & ~MdBusy → load MD_LATENCY.
  - Otherwise, if nonzero, decrement.
  - MdBusy = (count≠0).
  - MdStartD while MdBusy: also asserts MdUseD, so it stalls and is accepted on the cycle the count reaches 0.
  - MdStartD during a lwstall or branchstall is not accepted; the held instruction re-presents it.
  - A dependent mfhi issued right after a start sees MdBusy = 1 for exactly MD_LATENCY cycles.
- Simultaneous lwstall and mdstall: a single stall, with no double flush.

Decomposition:
- Shared package holds:
  - forward-select constants FWD_RF=0, FWD_WB=1, FWD_MEM=2;
  - REG_W.
- One natural sub-module, `md_busy_counter`: loadable down-counter with busy flag, parameterised by MD_LATENCY.
- Forward compare logic stays inline.

Test Plan:
- After rst, issue add $3 then sub $4,$3,$5 back-to-back → ForwardAE=2 in sub's E cycle; one instruction later with a gap → ForwardAE=1; no stall.
- lw $2, then add $6,$2,$2 → stall=1 for exactly 1 cycle with FlushE=1; next cycle ForwardAE=ForwardBE=1.
- Writes to $0 in M and W while RsE=RtE=0 → ForwardAE=ForwardBE=0; lw $0 followed by a use of $0 → no stall.
- add $8 then beq $8,$9 → branchstall for 1 cycle, then ForwardAD=1. lw $8 then beq $8 → 2 stall cycles.
- MD_LATENCY=4: mult, then mflo immediately → StallD=1 for 4 cycles, MdBusy falls, mflo proceeds; a second mult during busy is accepted on the cycle the count hits 0.
- Assert rst with count=3 → next cycle MdBusy=0, all outputs 0, shadow regs cleared.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared widths, forward-select codes and the forward priority helper
package hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_WB = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] wr_m,
    input logic             rw_m,
    input logic [REG_W-1:0] wr_w,
    input logic             rw_w
  );
    return (src != '0 && rw_m && src == wr_m) ? FWD_MEM :
           (src != '0 && rw_w && src == wr_w) ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage hazard inputs and the forward/stall controls
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;
  logic [REG_W-1:0] RsD, RtD, WriteRegD;
  logic             RegWriteD, MemtoRegD, BranchD, MdStartD, MdUseD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy;
  modport master (
    output RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, MdStartD, MdUseD,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy
  );
  modport slave (
    input  RsD, RtD, WriteRegD, RegWriteD, MemtoRegD, BranchD, MdStartD, MdUseD,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy
  );
endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// md_busy_counter: loadable down-counter tracking how long HI/LO stays occupied
module md_busy_counter #(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_busy
);
  localparam int CW = $clog2(MD_LATENCY + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= CW'(MD_LATENCY);
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end
  assign o_busy = r_cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stall/flush and mul/div busy tracking for the 5-stage pipe
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.slave hz
);
  logic [REG_W-1:0] r_rs_e, r_rt_e, r_wr_e, r_wr_m, r_wr_w;
  logic r_rw_e, r_rw_m, r_rw_w, r_mtr_e, r_mtr_m;
  logic w_lwstall, w_brstall, w_stall, w_busy, w_e_hit, w_m_hit;
  // a flushed E slot is a bubble: all-zero fields never match or write
  always_ff @(posedge clk) begin
    r_rs_e  <= (rst || w_stall) ? '0 : hz.RsD;
    r_rt_e  <= (rst || w_stall) ? '0 : hz.RtD;
    r_wr_e  <= (rst || w_stall) ? '0 : hz.WriteRegD;
    r_rw_e  <= !(rst || w_stall) && hz.RegWriteD;
    r_mtr_e <= !(rst || w_stall) && hz.MemtoRegD;
    r_wr_m  <= rst ? '0 : r_wr_e;
    r_rw_m  <= !rst && r_rw_e;
    r_mtr_m <= !rst && r_mtr_e;
    r_wr_w  <= rst ? '0 : r_wr_m;
    r_rw_w  <= !rst && r_rw_m;
  end
  assign w_e_hit   = r_wr_e != '0 && (r_wr_e == hz.RsD || r_wr_e == hz.RtD);
  assign w_m_hit   = r_wr_m != '0 && (r_wr_m == hz.RsD || r_wr_m == hz.RtD);
  assign w_lwstall = r_mtr_e && w_e_hit;
  assign w_brstall = hz.BranchD && ((r_rw_e && w_e_hit) || (r_mtr_m && w_m_hit));
  assign w_stall   = w_lwstall || w_brstall || (hz.MdUseD && w_busy);
  md_busy_counter #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk    (clk),
    .rst    (rst),
    .i_load (hz.MdStartD && !w_stall && !w_busy),
    .o_busy (w_busy)
  );
  assign hz.ForwardAE = fwd_sel(r_rs_e, r_wr_m, r_rw_m, r_wr_w, r_rw_w);
  assign hz.ForwardBE = fwd_sel(r_rt_e, r_wr_m, r_rw_m, r_wr_w, r_rw_w);
  assign hz.ForwardAD = hz.RsD != '0 && r_rw_m && hz.RsD == r_wr_m;
  assign hz.ForwardBD = hz.RtD != '0 && r_rw_m && hz.RtD == r_wr_m;
  assign hz.StallF    = w_stall;
  assign hz.StallD    = w_stall;
  assign hz.FlushE    = w_stall;
  assign hz.MdBusy    = w_busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed hazard scenarios plus random instruction streams against a slot-level model
module tb_hazard_ctrl;
  localparam int LAT = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  hazard_ctrl_if u_if();
  hazard_ctrl #(.MD_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .hz(u_if));
  typedef struct packed {logic [4:0] rs, rt, wr; logic rw, mtr;} slot_t;
  slot_t e, m, w;
  int cnt = 0, n_chk = 0, n_fail = 0;
  logic [1:0] x_fae, x_fbe;
  logic x_fad, x_fbd, x_stall, x_busy;
  function automatic logic [1:0] sel(input logic [4:0] s);
    if (s != 0 && m.rw && s == m.wr) return 2;
    if (s != 0 && w.rw && s == w.wr) return 1;
    return 0;
  endfunction
  function automatic logic uses(input logic [4:0] d);
    return d != 0 && (d == u_if.RsD || d == u_if.RtD);
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic sample();
    @(negedge clk);
    x_busy  = cnt != 0;
    x_fae   = sel(e.rs);
    x_fbe   = sel(e.rt);
    x_fad   = u_if.RsD != 0 && m.rw && u_if.RsD == m.wr;
    x_fbd   = u_if.RtD != 0 && m.rw && u_if.RtD == m.wr;
    x_stall = (e.mtr && uses(e.wr)) ||
              (u_if.BranchD && ((e.rw && uses(e.wr)) || (m.mtr && uses(m.wr)))) ||
              (u_if.MdUseD && x_busy);
    chk("ForwardAE", u_if.ForwardAE, x_fae);
    chk("ForwardBE", u_if.ForwardBE, x_fbe);
    chk("ForwardAD", u_if.ForwardAD, x_fad);
    chk("ForwardBD", u_if.ForwardBD, x_fbd);
    chk("StallF", u_if.StallF, x_stall);
    chk("StallD", u_if.StallD, x_stall);
    chk("FlushE", u_if.FlushE, x_stall);
    chk("MdBusy", u_if.MdBusy, x_busy);
  endtask
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      e = '0; m = '0; w = '0; cnt = 0;
    end else begin
      if (u_if.MdStartD && !x_stall && cnt == 0) cnt = LAT;
      else if (cnt > 0) cnt--;
      w = m;
      m = e;
      e = x_stall ? '0 : {u_if.RsD, u_if.RtD, u_if.WriteRegD, u_if.RegWriteD, u_if.MemtoRegD};
    end
    #1;
  endtask
  task automatic drive(input int rs, rt, wr, input bit rw, mtr, br, ms, mu);
    u_if.RsD = 5'(rs); u_if.RtD = 5'(rt); u_if.WriteRegD = 5'(wr);
    u_if.RegWriteD = rw; u_if.MemtoRegD = mtr; u_if.BranchD = br;
    u_if.MdStartD = ms; u_if.MdUseD = mu;
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    advance();
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    rst = 0;
    sample();
    chk("reset_outputs", {u_if.ForwardAE, u_if.ForwardBE, u_if.StallD, u_if.MdBusy}, 0);
    advance();
    // EX forwarding from M, then from W
    drive(1, 2, 3, 1, 0, 0, 0, 0); sample(); advance();
    drive(3, 5, 4, 1, 0, 0, 0, 0); sample(); chk("sub_no_stall", u_if.StallD, 0); advance();
    drive(3, 0, 7, 1, 0, 0, 0, 0); sample(); chk("sub_fwdA_mem", u_if.ForwardAE, 2); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("or_fwdA_wb", u_if.ForwardAE, 1); chk("or_fwdB_rf", u_if.ForwardBE, 0); advance();
    nop(); nop();
    // load-use
    drive(1, 0, 2, 1, 1, 0, 0, 0); sample(); advance();
    drive(2, 2, 6, 1, 0, 0, 0, 0); sample();
    chk("lw_stall", u_if.StallF, 1); chk("lw_flush", u_if.FlushE, 1); advance();
    sample(); chk("lw_stall_one", u_if.StallD, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("lw_fwdA_wb", u_if.ForwardAE, 1); chk("lw_fwdB_wb", u_if.ForwardBE, 1); advance();
    nop(); nop();
    // register 0
    drive(1, 0, 0, 1, 1, 0, 0, 0); sample(); advance();
    drive(0, 0, 9, 1, 0, 0, 0, 0); sample(); chk("r0_no_stall", u_if.StallD, 0); advance();
    drive(0, 0, 0, 1, 0, 0, 0, 0); sample();
    chk("r0_fwdA", u_if.ForwardAE, 0); chk("r0_fwdB", u_if.ForwardBE, 0); advance();
    nop(); nop();
    // branch after ALU op, then after load
    drive(1, 2, 8, 1, 0, 0, 0, 0); sample(); advance();
    drive(8, 9, 0, 0, 0, 1, 0, 0); sample(); chk("br_stall", u_if.StallD, 1); advance();
    sample(); chk("br_release", u_if.StallD, 0); chk("br_fwdAD", u_if.ForwardAD, 1);
    chk("br_fwdBD", u_if.ForwardBD, 0); advance();
    nop(); nop();
    drive(1, 0, 8, 1, 1, 0, 0, 0); sample(); advance();
    drive(8, 9, 0, 0, 0, 1, 0, 0); sample(); chk("lwbr_stall1", u_if.StallD, 1); advance();
    sample(); chk("lwbr_stall2", u_if.StallD, 1); advance();
    sample(); chk("lwbr_release", u_if.StallD, 0); advance();
    nop(); nop();
    // mult then mflo, and back-to-back mult
    drive(4, 5, 0, 0, 0, 0, 1, 1); sample(); chk("mult_accept", u_if.StallD, 0); advance();
    drive(0, 0, 10, 1, 0, 0, 0, 1);
    for (int i = 0; i < LAT; i++) begin
      sample(); chk("mflo_stall", u_if.StallD, 1); chk("mflo_busy", u_if.MdBusy, 1); advance();
    end
    sample(); chk("mflo_go", u_if.StallD, 0); chk("mflo_idle", u_if.MdBusy, 0); advance();
    nop();
    drive(4, 5, 0, 0, 0, 0, 1, 1); sample(); advance();
    for (int i = 0; i < LAT; i++) begin
      sample(); chk("mult2_stall", u_if.StallD, 1); advance();
    end
    sample(); chk("mult2_accept", u_if.StallD, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0); sample(); chk("mult2_busy", u_if.MdBusy, 1); advance();
    nop(); nop(); nop(); nop();
    // reset in the middle of a mul/div
    drive(4, 5, 0, 0, 0, 0, 1, 1); sample(); advance();
    drive(1, 2, 3, 1, 0, 0, 0, 0); sample(); advance();
    drive(3, 3, 0, 0, 0, 0, 0, 0); sample(); advance();
    rst = 1; drive(3, 3, 3, 1, 1, 1, 0, 1); sample(); advance();
    rst = 0; sample();
    chk("rst_mid_busy", u_if.MdBusy, 0);
    chk("rst_mid_outs", {u_if.ForwardAE, u_if.ForwardBE, u_if.ForwardAD, u_if.StallD}, 0);
    advance();
    // random streams; a stalled instruction is re-presented unchanged
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (!x_stall) begin
        automatic bit rw = $urandom_range(0, 1) == 1;
        automatic bit ms = $urandom_range(0, 9) == 0;
        drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rw,
              rw && $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, ms,
              ms || $urandom_range(0, 5) == 0);
      end
      sample();
      advance();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
